// File: rtl/comm_pkg.sv
// Shared types and constants for the channel output selector.
package comm_pkg;

    // Selector FSM states.
    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } sel_state_e;

    // Width of the blanking counter; holds BLANK_CYC values up to 15.
    localparam int CNT_W = 4;

    // Saturation value of the drop counter.
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Ceiling log2, minimum result 1 so a select field is never zero-width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_blank_timer.sv
// Blanking down-counter: loads BLANK_CYC, counts down to zero, flags the last cycle.
module sel_blank_timer
    import comm_pkg::*;
#(
    parameter int BLANK_CYC = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             load,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    // Load has priority so a restart in the middle of blanking begins a full period.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= CNT_W'(BLANK_CYC);
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == CNT_W'(1));

endmodule

// File: rtl/comm_out_sel.sv
// Channel output selector: registers one of NCH channels onto a single output
// slot, with blanking after a selection change and a saturating drop counter.
module comm_out_sel
    import comm_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int DW        = 16,
    parameter  int BLANK_CYC = 2,
    parameter  int RST_SEL   = 0,
    localparam int SELW      = clog2(NCH)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [SELW-1:0]   out_select,
    input  logic              sel_strobe,
    input  logic              hold,
    input  logic              out_ready,
    output logic [DW-1:0]     data_out,
    output logic              data_valid,
    output logic [SELW-1:0]   cur_sel,
    output logic              switching,
    output logic              sel_err,
    output logic [7:0]        drop_cnt
);

    sel_state_e       state_q;
    sel_state_e       state_d;
    logic [CNT_W-1:0] blank_value;
    logic             blank_done;
    logic             sel_in_range;
    logic             sel_ok;
    logic             slot_free;
    logic             beat;
    logic [DW-1:0]    sel_data;
    logic             capture;
    logic             drop;

    sel_blank_timer #(
        .BLANK_CYC(BLANK_CYC)
    ) u_blank_timer (
        .sysclk(sysclk),
        .reset (reset),
        .load  (sel_ok),
        .value (blank_value),
        .done  (blank_done)
    );

    // Request decode, slot status and capture/drop qualification.
    always_comb begin
        sel_in_range = (int'(out_select) < NCH);
        sel_ok       = sel_strobe && sel_in_range;
        slot_free    = !data_valid || out_ready;
        beat         = ch_valid[cur_sel];
        sel_data     = ch_data[int'(cur_sel)*DW +: DW];
        capture      = (state_q == RUN) && !hold && beat && slot_free;
        drop         = (state_q == RUN) && !hold && beat && !slot_free;
    end

    // Next-state logic; a valid request always (re)enters BLANK.
    always_comb begin
        state_d = state_q;
        if (sel_ok) begin
            state_d = BLANK;
        end else if ((state_q == BLANK) && blank_done) begin
            state_d = RUN;
        end
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign switching = (state_q == BLANK);

    // Output slot: capture uses the current selection even if a switch is requested this cycle.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (capture) begin
            data_out   <= sel_data;
            data_valid <= 1'b1;
        end else if (out_ready) begin
            data_valid <= 1'b0;
        end
    end

    // Selection, error pulse and drop counter bookkeeping.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cur_sel  <= SELW'(RST_SEL);
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sel_err <= sel_strobe && !sel_in_range;
            if (sel_ok) begin
                cur_sel  <= out_select;
                drop_cnt <= '0;
            end else if (drop && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_comm_out_sel.sv
// Directed self-checking bench for comm_out_sel (NCH=4 main instance, NCH=3 instance).
module tb_comm_out_sel;

    logic        sysclk;
    logic        reset;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [1:0]  out_select;
    logic        sel_strobe;
    logic        hold;
    logic        out_ready;

    logic [15:0] data_out;
    logic        data_valid;
    logic [1:0]  cur_sel;
    logic        switching;
    logic        sel_err;
    logic [7:0]  drop_cnt;

    logic [15:0] data_out_3;
    logic        data_valid_3;
    logic [1:0]  cur_sel_3;
    logic        switching_3;
    logic        sel_err_3;
    logic [7:0]  drop_cnt_3;

    int n_cmp  = 0;
    int n_fail = 0;

    comm_out_sel #(
        .NCH(4), .DW(16), .BLANK_CYC(2), .RST_SEL(0)
    ) dut (
        .sysclk(sysclk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
        .out_select(out_select), .sel_strobe(sel_strobe), .hold(hold),
        .out_ready(out_ready), .data_out(data_out), .data_valid(data_valid),
        .cur_sel(cur_sel), .switching(switching), .sel_err(sel_err),
        .drop_cnt(drop_cnt)
    );

    comm_out_sel #(
        .NCH(3), .DW(16), .BLANK_CYC(2), .RST_SEL(2)
    ) dut3 (
        .sysclk(sysclk), .reset(reset), .ch_data(ch_data[47:0]),
        .ch_valid(ch_valid[2:0]), .out_select(out_select),
        .sel_strobe(sel_strobe), .hold(hold), .out_ready(out_ready),
        .data_out(data_out_3), .data_valid(data_valid_3), .cur_sel(cur_sel_3),
        .switching(switching_3), .sel_err(sel_err_3), .drop_cnt(drop_cnt_3)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        n_cmp++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", data_valid); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL rst_cur_sel got %0d want 0", cur_sel); end
        n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL rst_switching got %b want 0", switching); end
        n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (cur_sel_3 !== 2'd2) begin n_fail++; $display("FAIL rst_cur_sel3 got %0d want 2", cur_sel_3); end
        reset = 1'b1;
    endtask

    task automatic test_capture();
        out_ready      = 1'b1;
        ch_data[15:0]  = 16'hA5A5;
        ch_valid       = 4'b0001;
        step();
        n_cmp++; if (data_out !== 16'hA5A5) begin n_fail++; $display("FAIL cap_data got %h want a5a5", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %b want 1", data_valid); end
        ch_valid = 4'b0000;
        step();
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL cap_clear got %b want 0", data_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [4];
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            ch_data[15:0] = vals[i];
            step();
        end
        n_cmp++; if (data_out !== 16'h1111) begin n_fail++; $display("FAIL bp_hold_data got %h want 1111", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", data_valid); end
        n_cmp++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL bp_drop got %0d want 3", drop_cnt); end
        ch_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", data_valid); end
    endtask

    task automatic test_drop_sat();
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        step();
        for (int i = 0; i < 260; i++) step();
        n_cmp++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_sat got %h want ff", drop_cnt); end
        ch_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        n_cmp++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_sat_keep got %h want ff", drop_cnt); end
    endtask

    task automatic test_switch();
        sel_strobe     = 1'b1;
        out_select     = 2'd2;
        ch_valid       = 4'b0100;
        ch_data[47:32] = 16'hC200;
        step();
        n_cmp++; if (cur_sel !== 2'd2) begin n_fail++; $display("FAIL sw_cur_sel got %0d want 2", cur_sel); end
        n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL sw_blank1 got %b want 1", switching); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sw_drop_clr got %0d want 0", drop_cnt); end
        sel_strobe     = 1'b0;
        ch_data[47:32] = 16'hC201;
        step();
        n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL sw_blank2 got %b want 1", switching); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL sw_discard1 got %b want 0", data_valid); end
        ch_data[47:32] = 16'hC202;
        step();
        n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL sw_run got %b want 0", switching); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL sw_discard2 got %b want 0", data_valid); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sw_no_drop got %0d want 0", drop_cnt); end
        ch_data[47:32] = 16'hC203;
        step();
        n_cmp++; if (data_out !== 16'hC203) begin n_fail++; $display("FAIL sw_first_cap got %h want c203", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL sw_first_valid got %b want 1", data_valid); end
        ch_valid = 4'b0000;
        step();
    endtask

    task automatic test_restart();
        sel_strobe = 1'b1;
        out_select = 2'd3;
        step();
        out_select = 2'd1;
        step();
        n_cmp++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL rs_cur_sel got %0d want 1", cur_sel); end
        n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL rs_blank1 got %b want 1", switching); end
        sel_strobe = 1'b0;
        step();
        n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL rs_blank2 got %b want 1", switching); end
        step();
        n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL rs_run got %b want 0", switching); end
    endtask

    task automatic test_coincide();
        ch_valid       = 4'b0010;
        ch_data[31:16] = 16'hB1B1;
        ch_data[15:0]  = 16'h0B0B;
        sel_strobe     = 1'b1;
        out_select     = 2'd0;
        step();
        n_cmp++; if (data_out !== 16'hB1B1) begin n_fail++; $display("FAIL co_old_sel got %h want b1b1", data_out); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL co_cur_sel got %0d want 0", cur_sel); end
        n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL co_blank got %b want 1", switching); end
        sel_strobe = 1'b0;
        ch_valid   = 4'b0000;
        step();
        step();
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL co_consumed got %b want 0", data_valid); end
    endtask

    task automatic test_hold();
        hold          = 1'b1;
        ch_valid      = 4'b0001;
        ch_data[15:0] = 16'hF0F0;
        step();
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL hold_discard got %b want 0", data_valid); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL hold_no_drop got %0d want 0", drop_cnt); end
        sel_strobe = 1'b1;
        out_select = 2'd2;
        step();
        n_cmp++; if (cur_sel !== 2'd2) begin n_fail++; $display("FAIL hold_strobe got %0d want 2", cur_sel); end
        sel_strobe = 1'b0;
        hold       = 1'b0;
        ch_valid   = 4'b0000;
        step();
        step();
    endtask

    task automatic test_slot_kept();
        out_ready      = 1'b0;
        ch_valid       = 4'b0100;
        ch_data[47:32] = 16'hD0D0;
        step();
        sel_strobe     = 1'b1;
        out_select     = 2'd0;
        ch_valid       = 4'b0001;
        ch_data[15:0]  = 16'hEEEE;
        step();
        sel_strobe = 1'b0;
        step();
        step();
        n_cmp++; if (data_out !== 16'hD0D0) begin n_fail++; $display("FAIL keep_data got %h want d0d0", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL keep_valid got %b want 1", data_valid); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL keep_drop got %0d want 0", drop_cnt); end
        ch_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL keep_release got %b want 0", data_valid); end
    endtask

    task automatic test_sel_err();
        reset = 1'b0;
        step();
        reset      = 1'b1;
        sel_strobe = 1'b1;
        out_select = 2'd3;
        step();
        n_cmp++; if (sel_err_3 !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", sel_err_3); end
        n_cmp++; if (cur_sel_3 !== 2'd2) begin n_fail++; $display("FAIL err_cur_sel got %0d want 2", cur_sel_3); end
        n_cmp++; if (switching_3 !== 1'b0) begin n_fail++; $display("FAIL err_state got %b want 0", switching_3); end
        n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL err_nch4 got %b want 0", sel_err); end
        sel_strobe = 1'b0;
        step();
        n_cmp++; if (sel_err_3 !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b want 0", sel_err_3); end
        step();
        step();
    endtask

    task automatic test_reset_mid_blank();
        out_ready      = 1'b0;
        ch_valid       = 4'b1100;
        ch_data[47:32] = 16'h1234;
        ch_data[63:48] = 16'h1234;
        step();
        ch_valid   = 4'b0000;
        sel_strobe = 1'b1;
        out_select = 2'd1;
        step();
        sel_strobe = 1'b0;
        n_cmp++; if ({switching_3, data_valid_3} !== 2'b11) begin n_fail++; $display("FAIL mid_setup got %b want 11", {switching_3, data_valid_3}); end
        reset = 1'b0;
        step();
        n_cmp++; if (data_out_3 !== 16'h0000) begin n_fail++; $display("FAIL mid_data got %h want 0000", data_out_3); end
        n_cmp++; if (data_valid_3 !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", data_valid_3); end
        n_cmp++; if (cur_sel_3 !== 2'd2) begin n_fail++; $display("FAIL mid_cur_sel got %0d want 2", cur_sel_3); end
        n_cmp++; if (switching_3 !== 1'b0) begin n_fail++; $display("FAIL mid_switching got %b want 0", switching_3); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL mid_cur_sel4 got %0d want 0", cur_sel); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid4 got %b want 0", data_valid); end
        reset          = 1'b1;
        out_ready      = 1'b1;
        ch_valid       = 4'b0101;
        ch_data[15:0]  = 16'h5A5A;
        ch_data[47:32] = 16'h5A5A;
        step();
        n_cmp++; if (data_out_3 !== 16'h5A5A) begin n_fail++; $display("FAIL post_rst_cap3 got %h want 5a5a", data_out_3); end
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_cap got %b want 1", data_valid); end
        n_cmp++; if (data_out !== 16'h5A5A) begin n_fail++; $display("FAIL post_rst_data got %h want 5a5a", data_out); end
    endtask

    initial begin
        reset      = 1'b0;
        ch_data    = '0;
        ch_valid   = '0;
        out_select = '0;
        sel_strobe = 1'b0;
        hold       = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_capture();
        test_backpressure();
        test_drop_sat();
        test_switch();
        test_restart();
        test_coincide();
        test_hold();
        test_slot_kept();
        test_sel_err();
        test_reset_mid_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/comm_out_sel.md
COMM_OUT_SEL -- requirements
Module: comm_out_sel

Interface
REQ-001 Parameter NCH, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter DW, default 16: channel and output data width in bits.
REQ-003 Parameter BLANK_CYC, default 2: blanking cycles after a selection change; legal range 1..15.
REQ-004 Parameter RST_SEL, default 0: channel selected after reset; must be less than NCH.
REQ-005 Derived SELW = clog2(NCH): width of the select fields.
REQ-006 sysclk  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 ch_data  in  NCH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-009 ch_valid  in  NCH  per-channel beat-valid strobes.
REQ-010 out_select  in  SELW  requested channel.
REQ-011 sel_strobe  in  1  apply out_select; sampled once per cycle.
REQ-012 hold  in  1  freezes capture while high.
REQ-013 out_ready  in  1  downstream accepts data_out.
REQ-014 data_out  out  DW  registered selected data.
REQ-015 data_valid  out  1  data_out holds an unconsumed beat.
REQ-016 cur_sel  out  SELW  channel currently in effect.
REQ-017 switching  out  1  high while in BLANK.
REQ-018 sel_err  out  1  one-cycle pulse flagging an out-of-range request.
REQ-019 drop_cnt  out  8  count of selected-channel beats lost to backpressure.

Function
REQ-020 The FSM shall have two states, RUN and BLANK; switching shall equal (state==BLANK).
REQ-021 The output slot shall be free when data_valid==0 or out_ready==1.
REQ-022 In RUN with hold==0, ch_valid[cur_sel]==1 and a free slot, the block shall load ch_data[cur_sel] into data_out and set data_valid next cycle (latency 1).
REQ-023 When data_valid==1, out_ready==1 and no new load occurs, data_valid shall clear next cycle.
REQ-024 When data_valid==1 and out_ready==0, data_out and data_valid shall hold unchanged.
REQ-025 In RUN with hold==0, if ch_valid[cur_sel]==1 and the slot is not free, drop_cnt shall increment, saturating at 8'hFF.
REQ-026 A beat arriving while hold==1 or in BLANK shall be discarded and shall not increment drop_cnt.
REQ-027 sel_strobe==1 with out_select<NCH shall load cur_sel next cycle, clear drop_cnt, load the blank counter with BLANK_CYC, and enter BLANK.
REQ-028 sel_strobe==1 with out_select>=NCH shall pulse sel_err for one cycle and leave cur_sel, the state and drop_cnt unchanged; this case is possible only when NCH is not a power of two.
REQ-029 A valid sel_strobe in BLANK shall update cur_sel and reload the counter to BLANK_CYC (restart).
REQ-030 BLANK shall decrement the counter once per cycle and return to RUN on the cycle after the counter reaches 1.
REQ-031 A beat already in the slot at switch time shall remain until accepted; it shall never be dropped or overwritten.
REQ-032 When a valid sel_strobe and a capture coincide in a RUN cycle, the capture shall use the old cur_sel and the switch shall take effect next cycle.
REQ-033 A valid sel_strobe with out_select==cur_sel shall still enter BLANK and clear drop_cnt.
REQ-034 The hold input shall not block sel_strobe processing.

Reset
REQ-035 While reset==0 at a clock edge: data_out=0, data_valid=0, cur_sel=RST_SEL, state=RUN, blank counter=0, sel_err=0, drop_cnt=0.
REQ-036 A reset asserted mid-BLANK or with a pending beat shall discard both; the first capture shall be possible on the first cycle after reset deasserts.

Structure
REQ-037 Package comm_pkg shall hold the state enum (RUN, BLANK), the clog2 function and the drop-counter saturation constant 8'hFF.
REQ-038 The blank counter shall be a sub-module sel_blank_timer, with load, value and done ports, instantiated once.
REQ-039 Channel extraction shall be an indexed part-select; the block shall contain no latches and no combinational path from ch_data to data_out.

Verification
REQ-040 NCH=4, DW=16, out_ready=1, cur_sel=0, ch_valid=4'b0001 with ch_data[15:0]=16'hA5A5 -> data_out=16'hA5A5 and data_valid=1 one cycle later.
REQ-041 out_ready=0 with 3 further valid beats on the selected channel -> data_out holds its first value and drop_cnt=3; then out_ready=1 -> data_valid clears the next cycle.
REQ-042 sel_strobe with out_select=2 and BLANK_CYC=2 -> cur_sel=2, switching high for 2 cycles, channel-2 beats during those cycles discarded, first capture on cycle 3.
REQ-043 NCH=3, sel_strobe with out_select=3 -> sel_err pulses for 1 cycle and cur_sel is unchanged.
REQ-044 Second strobe (out_select=1) one cycle into BLANK -> cur_sel=1 and BLANK extends to 2 cycles after that strobe.
REQ-045 Reset low for 1 cycle during BLANK with data_valid=1 -> all outputs at reset values and cur_sel=RST_SEL.
